prism_state_engine: RTL and testbench

//  Execution core of the PRISM peripheral. Consumes the 8 x 80-bit latched config

---
 rtl/prism_state_engine.sv | 175 +++++++++++++++++
 tb/tb_prism_state_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prism_state_engine.sv
// ============================================================================
// prism_state_engine
// ----------------------------------------------------------------------------
// Execution core of the PRISM peripheral. Runs a programmable state machine of
// up to eight states over the synchronized input pins. Each state's behaviour
// comes from one word of the latched config table. The engine drives the
// output pins, a 16-bit dwell counter and a sticky interrupt flag.
//
// Ports
//   clk        in   project clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   run control; low returns the engine to idle on the next edge
//   cfg_busy   in   config loader mid-write; high freezes state/count/out_data
//   config_bus in   WIDTH*DEPTH config table; state S word at [S*WIDTH +: WIDTH]
//   in_data    in   synchronized input pins
//   irq_clr    in   single-cycle clear strobe for irq
//   out_data   out  registered output pins
//   state      out  current state index
//   count      out  dwell counter for the current state
//   irq        out  sticky interrupt flag
//
// Config word fields (bits [79:42] reserved):
//   [2:0] jmpA  [5:3] jmpB  [8:6] selA  [9] polA  [12:10] selB  [13] polB
//   [14] enB  [22:15] outv  [23] irq_on_entry  [24] cntA_en  [40:25] cmp
//   [41] sat_stop
// ============================================================================
module prism_state_engine #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   cfg_busy,
    input  logic [WIDTH*DEPTH-1:0] config_bus,
    input  logic [7:0]             in_data,
    input  logic                   irq_clr,
    output logic [7:0]             out_data,
    output logic [2:0]             state,
    output logic [15:0]            count,
    output logic                   irq
);

    // Only the low 42 bits of each word carry meaning; the rest is reserved.
    localparam int USED = 42;

    // What the engine does on the coming clock edge, in priority order.
    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_FROZEN,
        ACT_JUMP,
        ACT_DWELL
    } stepAction_e;

    logic [2:0]      r_state;
    logic [15:0]     r_count;
    logic [7:0]      r_outData;
    logic            r_irq;

    logic [USED-1:0] w_curWord;
    logic [USED-1:0] w_tgtWord;
    logic [2:0]      w_jmpA;
    logic [2:0]      w_jmpB;
    logic [2:0]      w_selA;
    logic            w_polA;
    logic [2:0]      w_selB;
    logic            w_polB;
    logic            w_enB;
    logic [7:0]      w_curOutv;
    logic            w_cntAEn;
    logic [15:0]     w_cmp;
    logic            w_satStop;
    logic            w_condA;
    logic            w_condB;
    logic [2:0]      w_targetRaw;
    logic [2:0]      w_target;
    logic [7:0]      w_tgtOutv;
    logic            w_tgtIrq;
    stepAction_e     w_action;

    // Only the used field range is sliced out, so the reserved bits never
    // reach any logic.
    assign w_curWord = config_bus[int'(r_state)*WIDTH +: USED];
    assign w_tgtWord = config_bus[int'(w_target)*WIDTH +: USED];

    assign w_jmpA    = w_curWord[2:0];
    assign w_jmpB    = w_curWord[5:3];
    assign w_selA    = w_curWord[8:6];
    assign w_polA    = w_curWord[9];
    assign w_selB    = w_curWord[12:10];
    assign w_polB    = w_curWord[13];
    assign w_enB     = w_curWord[14];
    assign w_curOutv = w_curWord[22:15];
    assign w_cntAEn  = w_curWord[24];
    assign w_cmp     = w_curWord[40:25];
    assign w_satStop = w_curWord[41];

    assign w_tgtOutv = w_tgtWord[22:15];
    assign w_tgtIrq  = w_tgtWord[23];

    // Condition A may additionally be gated on the dwell count, so a state can
    // wait for an exact number of cycles before following exit A.
    assign w_condA = (in_data[w_selA] ^ w_polA) & (~w_cntAEn | (r_count == w_cmp));
    assign w_condB = w_enB & (in_data[w_selB] ^ w_polB);

    // Exit A wins over exit B. A target outside the populated table falls
    // back to state 0 so a bad config can never strand the engine.
    assign w_targetRaw = w_condA ? w_jmpA : w_jmpB;
    assign w_target    = ({1'b0, w_targetRaw} >= 4'(DEPTH)) ? 3'd0 : w_targetRaw;

    // Disable beats a config write in progress, which beats normal stepping.
    always_comb begin
        w_action = ACT_DWELL;
        if (!enable) begin
            w_action = ACT_IDLE;
        end else if (cfg_busy) begin
            w_action = ACT_FROZEN;
        end else if (w_condA || w_condB) begin
            w_action = ACT_JUMP;
        end
    end

    // All engine state lives here. On a jump the outputs take the target
    // state's pattern at once; while dwelling they track the current word, so
    // a live reconfig of the current state shows up on the pins immediately.
    // irq sits outside the action case because it is independent of enable
    // and cfg_busy: only an entry event sets it, and a set in the same cycle
    // as a clear strobe must win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= 3'd0;
            r_count   <= 16'd0;
            r_outData <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            case (w_action)
                ACT_IDLE: begin
                    r_state   <= 3'd0;
                    r_count   <= 16'd0;
                    r_outData <= 8'h00;
                end
                ACT_FROZEN: begin
                    r_state   <= r_state;
                    r_count   <= r_count;
                    r_outData <= r_outData;
                end
                ACT_JUMP: begin
                    r_state   <= w_target;
                    r_count   <= 16'd0;
                    r_outData <= w_tgtOutv;
                end
                default: begin
                    if (w_satStop && (r_count == w_cmp)) begin
                        r_count <= r_count;
                    end else if (r_count != 16'hFFFF) begin
                        r_count <= r_count + 16'd1;
                    end
                    r_outData <= w_curOutv;
                end
            endcase

            if ((w_action == ACT_JUMP) && w_tgtIrq) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign out_data = r_outData;
    assign state    = r_state;
    assign count    = r_count;
    assign irq      = r_irq;

endmodule

// File: tb/tb_prism_state_engine.sv
// ============================================================================
// tb_prism_state_engine
// ----------------------------------------------------------------------------
// Directed bench for prism_state_engine. Each scenario task builds a config
// table, drives inputs on the falling edge and checks the registered outputs
// on the following falling edge against hand-computed values.
// ============================================================================
module tb_prism_state_engine;

    localparam int WIDTH = 80;
    localparam int DEPTH = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic                   cfg_busy;
    logic [WIDTH*DEPTH-1:0] cfgBus;
    logic [7:0]             inData;
    logic                   irqClr;
    logic [7:0]             outData;
    logic [2:0]             state;
    logic [15:0]            count;
    logic                   irq;

    int vectorsApplied = 0;
    int miscompares    = 0;

    prism_state_engine #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_busy   (cfg_busy),
        .config_bus (cfgBus),
        .in_data    (inData),
        .irq_clr    (irqClr),
        .out_data   (outData),
        .state      (state),
        .count      (count),
        .irq        (irq)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs one config word from its fields.
    function automatic logic [79:0] mkWord(
        input logic [2:0]  jmpA,
        input logic [2:0]  jmpB,
        input logic [2:0]  selA,
        input logic        polA,
        input logic [2:0]  selB,
        input logic        polB,
        input logic        enB,
        input logic [7:0]  outv,
        input logic        irqE,
        input logic        cntEn,
        input logic [15:0] cmp,
        input logic        satStop
    );
        mkWord = {38'd0, satStop, cmp, cntEn, irqE, outv, enB, polB, selB,
                  polA, selA, jmpB, jmpA};
    endfunction

    task automatic setWord(input int idx, input logic [79:0] w);
        cfgBus[idx*WIDTH +: WIDTH] = w;
    endtask

    // Advances one clock; returns on the falling edge, where outputs are stable.
    task automatic stepClk();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns the engine to idle with a clean table.
    task automatic goIdle();
        enable   = 1'b0;
        cfg_busy = 1'b0;
        irqClr   = 1'b0;
        inData   = 8'h00;
        stepClk();
        cfgBus   = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectorsApplied++;
        if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        vectorsApplied++;
        if (count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        vectorsApplied++;
        if (outData !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_out got %h want 00", outData); end
        vectorsApplied++;
        if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
        rst_n = 1'b1;
    endtask

    task automatic test_dwell();
        setWord(0, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5,
                          1'b0, 1'b0, 16'd0, 1'b0));
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            stepClk();
            vectorsApplied++;
            if (outData !== 8'hA5) begin miscompares++; $display("[TB] FAIL dwell_out[%0d] got %h want a5", i, outData); end
            vectorsApplied++;
            if (count !== 16'(i)) begin miscompares++; $display("[TB] FAIL dwell_count[%0d] got %0d want %0d", i, count, i); end
            vectorsApplied++;
            if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL dwell_state[%0d] got %0d want 0", i, state); end
        end
    endtask

    task automatic test_jump_irq();
        goIdle();
        setWord(0, mkWord(3'd2, 3'd0, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5,
                          1'b0, 1'b0, 16'd0, 1'b0));
        setWord(2, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h3C,
                          1'b1, 1'b0, 16'd0, 1'b0));
        enable = 1'b1;
        inData = 8'h08;
        stepClk();
        vectorsApplied++;
        if (state !== 3'd2) begin miscompares++; $display("[TB] FAIL jump_state got %0d want 2", state); end
        vectorsApplied++;
        if (outData !== 8'h3C) begin miscompares++; $display("[TB] FAIL jump_out got %h want 3c", outData); end
        vectorsApplied++;
        if (count !== 16'd0) begin miscompares++; $display("[TB] FAIL jump_count got %0d want 0", count); end
        vectorsApplied++;
        if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL jump_irq got %b want 1", irq); end
        inData = 8'h00;
        irqClr = 1'b1;
        stepClk();
        irqClr = 1'b0;
        vectorsApplied++;
        if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_clear got %b want 0", irq); end
        vectorsApplied++;
        if (count !== 16'd1) begin miscompares++; $display("[TB] FAIL post_jump_count got %0d want 1", count); end
    endtask

    task automatic test_priority();
        goIdle();
        setWord(0, mkWord(3'd1, 3'd4, 3'd1, 1'b0, 3'd2, 1'b0, 1'b1, 8'hA5,
                          1'b0, 1'b0, 16'd0, 1'b0));
        setWord(1, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11,
                          1'b0, 1'b0, 16'd0, 1'b0));
        setWord(4, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h44,
                          1'b0, 1'b0, 16'd0, 1'b0));
        enable = 1'b1;
        inData = 8'h06;
        stepClk();
        vectorsApplied++;
        if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL both_state got %0d want 1", state); end
        vectorsApplied++;
        if (outData !== 8'h11) begin miscompares++; $display("[TB] FAIL both_out got %h want 11", outData); end
        enable = 1'b0;
        stepClk();
        enable = 1'b1;
        inData = 8'h04;
        stepClk();
        vectorsApplied++;
        if (state !== 3'd4) begin miscompares++; $display("[TB] FAIL onlyB_state got %0d want 4", state); end
        vectorsApplied++;
        if (outData !== 8'h44) begin miscompares++; $display("[TB] FAIL onlyB_out got %h want 44", outData); end
        vectorsApplied++;
        if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL onlyB_irq got %b want 0", irq); end
    endtask

    task automatic test_count_compare();
        goIdle();
        setWord(0, mkWord(3'd1, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 8'hA5,
                          1'b0, 1'b0, 16'd0, 1'b0));
        setWord(1, mkWord(3'd3, 3'd0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11,
                          1'b0, 1'b1, 16'd5, 1'b0));
        setWord(3, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h33,
                          1'b0, 1'b0, 16'd0, 1'b0));
        enable = 1'b1;
        inData = 8'h02;
        stepClk();
        vectorsApplied++;
        if (state !== 3'd1 || count !== 16'd0) begin miscompares++; $display("[TB] FAIL cmp_entry got state %0d count %0d want 1/0", state, count); end
        for (int i = 1; i <= 5; i++) begin
            stepClk();
            vectorsApplied++;
            if (state !== 3'd1 || count !== 16'(i)) begin miscompares++; $display("[TB] FAIL cmp_wait[%0d] got state %0d count %0d want 1/%0d", i, state, count, i); end
        end
        stepClk();
        vectorsApplied++;
        if (state !== 3'd3) begin miscompares++; $display("[TB] FAIL cmp_jump_state got %0d want 3", state); end
        vectorsApplied++;
        if (outData !== 8'h33 || count !== 16'd0) begin miscompares++; $display("[TB] FAIL cmp_jump_out got %h/%0d want 33/0", outData, count); end
    endtask

    task automatic test_freeze_enable();
        goIdle();
        setWord(0, mkWord(3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5,
                          1'b0, 1'b0, 16'd0, 1'b0));
        setWord(5, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h55,
                          1'b1, 1'b0, 16'd0, 1'b0));
        enable = 1'b1;
        stepClk();
        stepClk();
        cfg_busy = 1'b1;
        inData   = 8'h01;
        for (int i = 1; i <= 3; i++) begin
            stepClk();
            vectorsApplied++;
            if (state !== 3'd0 || count !== 16'd2 || outData !== 8'hA5) begin
                miscompares++;
                $display("[TB] FAIL busy_hold[%0d] got state %0d count %0d out %h want 0/2/a5", i, state, count, outData);
            end
        end
        cfg_busy = 1'b0;
        stepClk();
        inData = 8'h00;
        vectorsApplied++;
        if (state !== 3'd5 || outData !== 8'h55 || count !== 16'd0) begin miscompares++; $display("[TB] FAIL busy_resume got state %0d out %h count %0d want 5/55/0", state, outData, count); end
        vectorsApplied++;
        if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_resume_irq got %b want 1", irq); end
        enable = 1'b0;
        stepClk();
        vectorsApplied++;
        if (state !== 3'd0 || outData !== 8'h00 || count !== 16'd0) begin miscompares++; $display("[TB] FAIL disable got state %0d out %h count %0d want 0/00/0", state, outData, count); end
        vectorsApplied++;
        if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL disable_irq got %b want 1", irq); end
        enable   = 1'b1;
        cfg_busy = 1'b1;
        irqClr   = 1'b1;
        stepClk();
        irqClr   = 1'b0;
        cfg_busy = 1'b0;
        vectorsApplied++;
        if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_irq_clr got %b want 0", irq); end
        vectorsApplied++;
        if (state !== 3'd0 || count !== 16'd0) begin miscompares++; $display("[TB] FAIL busy_idle_hold got state %0d count %0d want 0/0", state, count); end
    endtask

    task automatic test_saturation();
        goIdle();
        setWord(0, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5,
                          1'b0, 1'b0, 16'd0, 1'b0));
        enable = 1'b1;
        repeat (65534) stepClk();
        vectorsApplied++;
        if (count !== 16'hFFFE) begin miscompares++; $display("[TB] FAIL sat_before got %h want fffe", count); end
        stepClk();
        vectorsApplied++;
        if (count !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_reach got %h want ffff", count); end
        repeat (5) stepClk();
        vectorsApplied++;
        if (count !== 16'hFFFF || state !== 3'd0) begin miscompares++; $display("[TB] FAIL sat_hold got %h state %0d want ffff/0", count, state); end
        // Live reconfig into a self-loop with a new pattern.
        setWord(0, mkWord(3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h5A,
                          1'b0, 1'b0, 16'd0, 1'b0));
        stepClk();
        vectorsApplied++;
        if (count !== 16'd0 || outData !== 8'h5A || state !== 3'd0) begin miscompares++; $display("[TB] FAIL self_jump got count %0d out %h state %0d want 0/5a/0", count, outData, state); end
        setWord(0, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5,
                          1'b0, 1'b0, 16'd3, 1'b1));
        repeat (5) stepClk();
        vectorsApplied++;
        if (count !== 16'd3 || outData !== 8'hA5) begin miscompares++; $display("[TB] FAIL sat_stop got count %0d out %h want 3/a5", count, outData); end
    endtask

    task automatic test_irq_set_wins();
        goIdle();
        setWord(0, mkWord(3'd6, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 8'hA5,
                          1'b0, 1'b0, 16'd0, 1'b0));
        setWord(6, mkWord(3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h66,
                          1'b1, 1'b0, 16'd0, 1'b0));
        enable = 1'b1;
        irqClr = 1'b1;
        stepClk();
        vectorsApplied++;
        if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL set_wins_irq got %b want 1", irq); end
        vectorsApplied++;
        if (state !== 3'd6 || outData !== 8'h66) begin miscompares++; $display("[TB] FAIL set_wins_state got %0d out %h want 6/66", state, outData); end
        stepClk();
        irqClr = 1'b0;
        vectorsApplied++;
        if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_after_set got %b want 0", irq); end
        // Asynchronous reset mid-run, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        vectorsApplied++;
        if (state !== 3'd0 || count !== 16'd0 || outData !== 8'h00) begin miscompares++; $display("[TB] FAIL async_reset got state %0d count %0d out %h want 0/0/00", state, count, outData); end
        @(negedge clk);
        rst_n = 1'b1;
        stepClk();
        vectorsApplied++;
        if (state !== 3'd6 || outData !== 8'h66) begin miscompares++; $display("[TB] FAIL post_reset_run got state %0d out %h want 6/66", state, outData); end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        cfg_busy = 1'b0;
        irqClr   = 1'b0;
        inData   = 8'h00;
        cfgBus   = '0;
        test_reset();
        test_dwell();
        test_jump_irq();
        test_priority();
        test_count_compare();
        test_freeze_enable();
        test_saturation();
        test_irq_set_wins();
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
